// File: rtl/bcd_digit_counter_pkg.sv
// bcd_pkg: shared BCD digit types, limits and the up/down step function
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
  typedef logic [3:0] bcd_t;
  // returns {wrap, next}; any out-of-range input lands on 0 without a wrap
  function automatic logic [4:0] bcd_step(bcd_t d, logic up);
    if (d > BCD_MAX) return {1'b0, BCD_MIN};
    return up ? ((d == BCD_MAX) ? {1'b1, BCD_MIN} : {1'b0, d + 4'd1})
              : ((d == BCD_MIN) ? {1'b1, BCD_MAX} : {1'b0, d - 4'd1});
  endfunction
endpackage

// File: rtl/bcd_digit_counter_if.sv
// bcd_digit_counter_if: control inputs and digit/strobe outputs of one BCD digit
// master drives en/up/clr (and preset_val/preset when BCD_DIGIT_PRESET_EN is defined),
// slave drives bcd_out/load/carry/borrow
interface bcd_digit_counter_if;
  import bcd_pkg::*;
  logic en;
  logic up;
  logic clr;
  bcd_t bcd_out;
  logic load;
  logic carry;
  logic borrow;
`ifdef BCD_DIGIT_PRESET_EN
  bcd_t preset_val;
  logic preset;
  modport master (output en, up, clr, preset_val, preset, input bcd_out, load, carry, borrow);
  modport slave (input en, up, clr, preset_val, preset, output bcd_out, load, carry, borrow);
`else
  modport master (output en, up, clr, input bcd_out, load, carry, borrow);
  modport slave (input en, up, clr, output bcd_out, load, carry, borrow);
`endif
endinterface

// File: rtl/bcd_digit_counter_tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV into a one-cycle count tick
// ports: clk, rst (sync, active high), en (gates counting), clr (restart at 0), tick (out)
module tick_prescaler #(
  parameter int TICK_DIV = 4,
  localparam int PS_W = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [PS_W-1:0] ps;
  assign tick = en && ps == PS_W'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) ps <= '0;
    else if (en) ps <= tick ? '0 : ps + 1'b1;
  end
endmodule

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: single BCD up/down digit with load strobe and carry/borrow chaining
// ports: clk, rst (sync, active high), bus (bcd_digit_counter_if.slave)
// BCD_DIGIT_PRESET_EN adds the preset_val/preset load path
module bcd_digit_counter
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input logic clk,
  input logic rst,
  bcd_digit_counter_if.slave bus
);
  bcd_t d;
  logic load, carry, borrow, armed, tick, restart, pre;
  logic [4:0] step;
`ifdef BCD_DIGIT_PRESET_EN
  assign pre = bus.preset;
`else
  assign pre = 1'b0;
`endif
  assign restart = bus.clr || pre;
  assign step = bcd_step(d, bus.up);
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_ps (
    .clk(clk), .rst(rst), .en(bus.en), .clr(restart), .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      d <= BCD_MIN;
      load <= 1'b0;
      carry <= 1'b0;
      borrow <= 1'b0;
      armed <= 1'b1;
    end else begin
      armed <= 1'b0;
      load <= armed;
      carry <= 1'b0;
      borrow <= 1'b0;
      if (bus.clr) begin
        d <= BCD_MIN;
        load <= 1'b1;
      end
`ifdef BCD_DIGIT_PRESET_EN
      else if (bus.preset) begin
        d <= (bus.preset_val > BCD_MAX) ? BCD_MAX : bus.preset_val;
        load <= 1'b1;
      end
`endif
      else if (d > BCD_MAX) begin
        d <= BCD_MIN;
        load <= 1'b1;
      end else if (tick) begin
        d <= step[3:0];
        load <= 1'b1;
        carry <= step[4] && bus.up;
        borrow <= step[4] && !bus.up;
      end
    end
  end
  assign bus.bcd_out = d;
  assign bus.load = load;
  assign bus.carry = carry;
  assign bus.borrow = borrow;
endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb_bcd_digit_counter: directed self-checking bench for bcd_digit_counter (TICK_DIV=4)
module tb_bcd_digit_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bcd_digit_counter_if bus();
  bcd_digit_counter #(.TICK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(string name, int cyc, logic [3:0] d, logic ld, logic c, logic b);
    checks++;
    if (bus.bcd_out !== d || bus.load !== ld || bus.carry !== c || bus.borrow !== b) begin
      errors++;
      $display("FAIL %s cyc %0d: got d=%0d load=%b carry=%b borrow=%b, want d=%0d load=%b carry=%b borrow=%b",
               name, cyc, bus.bcd_out, bus.load, bus.carry, bus.borrow, d, ld, c, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step_clk();
    expect_state("reset_hold", 0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step_clk();
    expect_state("reset_load", 1, 4'd0, 1'b1, 1'b0, 1'b0);
    step_clk();
    expect_state("reset_idle", 2, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_count_up();
    bus.en = 1'b1;
    bus.up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step_clk();
      expect_state("count_up", i, 4'((i / 4) % 10), i % 4 == 0, i == 40, 1'b0);
    end
  endtask

  task automatic test_count_down();
    bus.up = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step_clk();
      expect_state("count_down", i, 4'((10 - i / 4) % 10), i % 4 == 0, 1'b0, i == 4);
    end
  endtask

  task automatic test_enable_pause();
    repeat (2) step_clk();
    expect_state("pause_pre", 0, 4'd7, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step_clk();
      expect_state("pause_hold", i, 4'd7, 1'b0, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    step_clk();
    expect_state("pause_resume1", 1, 4'd7, 1'b0, 1'b0, 1'b0);
    step_clk();
    expect_state("pause_resume2", 2, 4'd6, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clr_on_tick();
    repeat (4) step_clk();
    expect_state("clr_pre", 0, 4'd5, 1'b1, 1'b0, 1'b0);
    repeat (3) step_clk();
    bus.clr = 1'b1;
    bus.up = 1'b1;
    step_clk();
    bus.clr = 1'b0;
    expect_state("clr_tick", 0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step_clk();
      expect_state("clr_after", i, i == 4 ? 4'd1 : 4'd0, i == 4, 1'b0, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    repeat (6) step_clk();
    expect_state("midrst_pre", 0, 4'd2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step_clk();
    expect_state("midrst_hit", 1, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step_clk();
    expect_state("midrst_load", 2, 4'd0, 1'b1, 1'b0, 1'b0);
    step_clk();
    expect_state("midrst_idle", 3, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef BCD_DIGIT_PRESET_EN
  task automatic test_preset();
    bus.en = 1'b0;
    bus.preset_val = 4'd12;
    bus.preset = 1'b1;
    step_clk();
    bus.preset = 1'b0;
    expect_state("preset_sat", 0, 4'd9, 1'b1, 1'b0, 1'b0);
    bus.preset_val = 4'd3;
    bus.preset = 1'b1;
    step_clk();
    bus.preset = 1'b0;
    expect_state("preset_3", 1, 4'd3, 1'b1, 1'b0, 1'b0);
    bus.preset_val = 4'd7;
    bus.preset = 1'b1;
    bus.clr = 1'b1;
    step_clk();
    bus.preset = 1'b0;
    bus.clr = 1'b0;
    expect_state("preset_clr", 2, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    bus.en = 1'b0;
    bus.up = 1'b1;
    bus.clr = 1'b0;
`ifdef BCD_DIGIT_PRESET_EN
    bus.preset = 1'b0;
    bus.preset_val = 4'd0;
`endif
    test_reset();
    test_count_up();
    test_count_down();
    test_enable_pause();
    test_clr_on_tick();
    test_mid_reset();
`ifdef BCD_DIGIT_PRESET_EN
    test_preset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
